// File: rtl/fpcvt_pkg.sv
// fpcvt_pkg: shared constants, fp8 encoding and FSM states for the fixed/float converters
package fpcvt_pkg;
  localparam int EXP_W = 3;
  localparam int SIG_W = 4;
  localparam int FIX_W = 12;
  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] sig;
  } fp8_t;
  typedef enum logic [1:0] {IDLE, SHIFT, FINISH, HOLD} state_t;
endpackage

// File: rtl/fp_expand_if.sv
// fp_expand_if: valid/ready input (fp8) and output (fixed) streams of the float expander
//   master: producer/consumer side (drives in_valid, in_fp, out_ready)
//   slave : expander side (drives in_ready, out_valid, out_val)
interface fp_expand_if;
  import fpcvt_pkg::*;
  logic             in_valid;
  logic             in_ready;
  fp8_t             in_fp;
  logic             out_valid;
  logic             out_ready;
  logic [FIX_W-1:0] out_val;
  modport master (output in_valid, in_fp, out_ready, input in_ready, out_valid, out_val);
  modport slave  (input in_valid, in_fp, out_ready, output in_ready, out_valid, out_val);
endinterface

// File: rtl/fp_sign_apply.sv
// fp_sign_apply: conditional two's complement negate of a FIX_W magnitude
//   neg in  : negate when high
//   mag in  : unsigned magnitude
//   res out : signed result
module fp_sign_apply
  import fpcvt_pkg::*;
(
  input  logic             neg,
  input  logic [FIX_W-1:0] mag,
  output logic [FIX_W-1:0] res
);
  always_comb res = neg ? -mag : mag;
endmodule

// File: rtl/fp_expand.sv
// fp_expand: 8-bit float {sign,exp,sig} to FIX_W two's complement, valid/ready streams
//   clk, rst : clock, synchronous active-high reset
//   bus      : fp_expand_if.slave (in_valid/in_ready/in_fp, out_valid/out_ready/out_val)
//   busy     : conversion or result pending
//   FP_EXPAND_FAST_EN defined: single-cycle barrel shift, full throughput
//   FP_EXPAND_FAST_EN undefined: iterative one-bit-per-cycle shift FSM
module fp_expand
  import fpcvt_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  fp_expand_if.slave  bus,
  output logic        busy
);
  if (FIX_W < SIG_W + 2**EXP_W) begin : g_fix_w_chk
    $error("fp_expand: FIX_W too small for SIG_W + 2**EXP_W");
  end
  logic [FIX_W-1:0] res;
`ifdef FP_EXPAND_FAST_EN
  logic [FIX_W-1:0] shifted;
  assign shifted = FIX_W'(bus.in_fp.sig) << bus.in_fp.exp;
  fp_sign_apply u_sign (.neg(bus.in_fp.sign), .mag(shifted), .res(res));
  // a new input may enter whenever the output register is free or being drained
  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign busy = bus.out_valid;
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_val   <= '0;
    end else if (bus.in_valid && bus.in_ready) begin
      bus.out_valid <= 1'b1;
      bus.out_val   <= res;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
`else
  state_t           state;
  logic             sign;
  logic [EXP_W-1:0] cnt;
  logic [FIX_W-1:0] mag;
  fp_sign_apply u_sign (.neg(sign), .mag(mag), .res(res));
  assign bus.in_ready = state == IDLE;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      sign          <= 1'b0;
      cnt           <= '0;
      mag           <= '0;
      bus.out_valid <= 1'b0;
      bus.out_val   <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          sign  <= bus.in_fp.sign;
          cnt   <= bus.in_fp.exp;
          mag   <= FIX_W'(bus.in_fp.sig);
          state <= bus.in_fp.exp != '0 ? SHIFT : FINISH;
        end
        SHIFT: begin
          mag   <= mag << 1;
          cnt   <= cnt - 1'b1;
          state <= cnt == EXP_W'(1) ? FINISH : SHIFT;
        end
        FINISH: begin
          bus.out_val   <= res;
          bus.out_valid <= 1'b1;
          state         <= HOLD;
        end
        HOLD: if (bus.out_ready) begin
          bus.out_valid <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif
endmodule

// File: tb/tb_fp_expand.sv
// tb_fp_expand: scoreboard bench for fp_expand (directed encodings, hold, reset abort, all 256 codes)
module tb_fp_expand;
  import fpcvt_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  always #5 clk = ~clk;
  fp_expand_if bus();
  fp_expand dut (.clk(clk), .rst(rst), .bus(bus), .busy(busy));
  int n_cmp = 0;
  int n_bad = 0;
  int n_out = 0;
  bit done = 1'b0;
  logic [FIX_W-1:0] sb[$];
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, want);
    end
  endtask
  function automatic logic [FIX_W-1:0] model(input logic [7:0] e);
    logic [FIX_W-1:0] m;
    m = FIX_W'(e[3:0]) << e[6:4];
    return e[7] ? -m : m;
  endfunction
  function automatic int lat_want(input logic [7:0] e);
`ifdef FP_EXPAND_FAST_EN
    return 1;
`else
    return int'(e[6:4]) + 2;
`endif
  endfunction
  always @(negedge clk) begin
    if (rst) sb.delete();
    else begin
      if (bus.in_valid && bus.in_ready) sb.push_back(model(bus.in_fp));
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        if (sb.size() == 0) check("sb_empty", 32'(bus.out_val), 32'hFFFF_FFFF);
        else check("sb_val", 32'(bus.out_val), 32'(sb.pop_front()));
      end
    end
  end
  // returns #1 after the edge on which the input transfer happens
  task automatic wait_xfer(input string tag);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.in_ready && k < 100);
    if (!bus.in_ready) check(tag, 0, 1);
    @(posedge clk);
    #1;
  endtask
  // edges counted with the transfer edge as edge 1
  task automatic wait_out(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask
  task automatic run(input logic [7:0] e, input logic [FIX_W-1:0] want);
    int lat;
    bus.in_fp = e;
    bus.in_valid = 1'b1;
    wait_xfer($sformatf("xfer_%02h", e));
    bus.in_valid = 1'b0;
    wait_out(lat);
    check($sformatf("lat_%02h", e), 32'(lat), 32'(lat_want(e)));
    check($sformatf("val_%02h", e), 32'(bus.out_val), 32'(want));
    @(posedge clk);
    #1;
  endtask
  initial begin
    int lat;
    int start;
    bus.in_valid = 1'b0;
    bus.in_fp = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(bus.out_valid), 0);
    check("rst_val", 32'(bus.out_val), 0);
    check("rst_ready", 32'(bus.in_ready), 1);
    check("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    run(8'h2B, 12'd44);
    run(8'h2C, 12'd48);
    run(8'hFF, 12'h880);
    run(8'h80, 12'h000);
    run(8'h07, 12'd7);
    run(8'h00, 12'h000);
    run(8'h97, 12'hFF2);
    bus.out_ready = 1'b0;
    bus.in_fp = 8'h2B;
    bus.in_valid = 1'b1;
    wait_xfer("hold_xfer");
    bus.in_valid = 1'b0;
    wait_out(lat);
    for (int i = 0; i < 3; i++) begin
      bus.in_fp = 8'hFF;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      check("hold_val", 32'(bus.out_val), 32'd44);
      check("hold_valid", 32'(bus.out_valid), 1);
      check("hold_ready", 32'(bus.in_ready), 0);
    end
    bus.in_valid = 1'b0;
    start = n_out;
    bus.out_ready = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("hold_one", 32'(n_out - start), 1);
    bus.in_fp = 8'hFF;
    bus.in_valid = 1'b1;
    wait_xfer("abort_xfer");
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_valid", 32'(bus.out_valid), 0);
    check("abort_ready", 32'(bus.in_ready), 1);
    check("abort_val", 32'(bus.out_val), 0);
    start = n_out;
    run(8'h11, 12'd2);
    check("abort_one", 32'(n_out - start), 1);
    start = n_out;
    fork
      begin
        for (int i = 0; i < 256; i++) begin
          bus.in_fp = 8'(i);
          bus.in_valid = 1'b1;
          wait_xfer("rnd_xfer");
          bus.in_valid = 1'b0;
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          bus.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.out_ready = 1'b1;
    for (int k = 0; k < 50 && sb.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    check("rnd_drain", 32'(sb.size()), 0);
    check("rnd_count", 32'(n_out - start), 256);
`ifdef FP_EXPAND_FAST_EN
    start = n_out;
    for (int i = 0; i < 8; i++) begin
      bus.in_fp = 8'(8'h13 + 8'(i * 17));
      bus.in_valid = 1'b1;
      @(negedge clk);
      check("b2b_ready", 32'(bus.in_ready), 1);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    #1;
    check("b2b_count", 32'(n_out - start), 8);
`endif
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
